exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM-subset pipeline. It consumes the ID/EXE pipeline register outputs, generates the second operand (Val2), runs the ALU and computes the branch target. It owns the NZCV status register and latches results into the EXE/MEM pipeline register that feeds the memory stage.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `WB_EN_IN`, `MEM_R_EN_IN`, `MEM_W_EN_IN`  in  1 each  control bits from ID/EXE.
- `B_IN`  in  1  branch instruction.
- `S_IN`  in  1  update status register.
- `EXE_CMD_IN`  in  4  ALU opcode.
- `PC_IN`  in  32  PC+4 of the instruction.
- `VAL_RN_IN`  in  32  Rn operand.
- `VAL_RM_IN`  in  32  Rm operand.
- `IMM_IN`  in  1  shifter operand is a rotated immediate.
- `ShiftOperand_IN`  in  12  instr[11:0].
- `Signed_IMM_24_IN`  in  24  branch offset.
- `Dest_IN`  in  4  destination register.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN`  out  1 each  registered control to MEM.
- `ALU_RES`  out  32  registered ALU result or address.
- `VAL_RM`  out  32  registered Rm (store data).
- `Dest`  out  4  registered destination.
- `Branch_Taken`  out  1  combinational; equals `B_IN`. Drives IF PC select and IF/ID and ID/EXE flush.
- `Branch_Addr`  out  32  combinational branch target.
- `Status`  out  4  NZCV register {N,Z,C,V}. Feeds the condition check in ID.

## Operation
- **ALU opcodes (`EXE_CMD_IN`):**
  - MOV 0001: Val2.
  - MVN 1001: ~Val2.
  - ADD 0010: Rn+Val2.
  - ADC 0011: Rn+Val2+C.
  - SUB 0100: Rn−Val2.
  - SBC 0101: Rn−Val2−(~C).
  - AND 0110, ORR 0111, EOR 1000: bitwise Rn op Val2.
  - CMP reuses 0100 and TST reuses 0110; the ID stage suppresses WB for both.
  - LDR and STR use 0010.
  - Any undefined code gives result 0 and flags 0.
- **Flags:**
  - N = res[31].
  - Z = (res == 0).
  - For ADD/ADC, C is the 33rd bit of the unsigned sum.
  - For SUB/SBC, C is NOT borrow (Rn ≥ subtrahend, unsigned).
  - V is the signed overflow of the add/sub.
  - Logic and move ops give C = 0 and V = 0.
- **Val2 generation:**
  - Memory op (`MEM_R_EN_IN | MEM_W_EN_IN`): Val2 = zero-extended ShiftOperand[11:0]. This case has priority.
  - Else if `IMM_IN`: Val2 = ROR({24'b0, SO[7:0]}, 2·SO[11:8]).
  - Else: Rm is shifted by SO[11:7] (0–31). SO[6:5] selects the shift: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm unchanged for every type.
- **Branch:** `Branch_Addr` = PC_IN + (sign_extend(Signed_IMM_24_IN) << 2), with a 32-bit wrap.
- **Status register:** loads {N,Z,C,V} at the clock edge when `S_IN` = 1. Otherwise it holds.

## Timing
- **EXE/MEM register:**
  - 1-cycle latency: `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `ALU_RES`, `VAL_RM` and `Dest` update on the edge after the inputs are presented.
  - There is no enable and no bubble logic; flush is the ID/EXE register's job.
- **Status:** a flag update by the instruction in EXE in cycle n is visible to the ID condition check in cycle n+1.
  - ADC/SBC in cycle n use the Status value held during cycle n, not the value being written at the end of that cycle.
  - Back-to-back S instructions each see the previous instruction's flags.
- **Branch:** `Branch_Taken` and `Branch_Addr` are combinational within the same cycle. No internal flop.
- **Reset:** while `rst` = 1 at an edge, every registered output and `Status` becomes 0, overriding any simultaneous `S_IN` or data. A reset mid-stream discards the in-flight result; after reset is released, the first edge captures the current inputs.

## Structure
- Package `arm_pkg`:
  - EXE_CMD localparams (`CMD_MOV` … `CMD_EOR`).
  - Shift-type enum `shift_t` {LSL, LSR, ASR, ROR}.
  - Flag index constants (N=3, Z=2, C=1, V=0).
- Sub-module `val2_gen`: combinational. Inputs are Rm, ShiftOperand, IMM and is_mem; output is Val2.
- The ALU stays inline in `exe_stage`, together with the status register and the EXE/MEM register.

## Test plan
- **ADD signed overflow:** S=1, Rn=0x7FFFFFFF, IMM with SO=0x001, ADD → next cycle ALU_RES=0x80000000 and Status=1001 (N, V).
- **SUB to zero:** S=1, Rn=5, Rm=5, SUB → ALU_RES=0 and Status=0110 (Z, C). The following ADC with Rn=1, Val2=1 yields 3.
- **Immediate rotate:** IMM=1, SO=0x4FF, MOV → ALU_RES=0xFF000000.
- **Register shift:**
  - Rm=0x80000000 with ASR #4 (SO=0x240) → 0xF8000000.
  - The same Rm with ROR #0 → 0x80000000 unchanged.
- **Memory and branch:**
  - STR with Rn=0x100 and SO=0x0FC → ALU_RES=0x1FC, VAL_RM equals the input Rm, MEM_W_EN=1 after 1 cycle.
  - B with PC_IN=0x20 and Signed_IMM_24=0xFFFFFE → Branch_Taken=1 and Branch_Addr=0x18 in the same cycle.
- **Reset priority:** assert rst together with S=1 and SUB → all outputs and Status are 0 on the next edge, and Status stays 0 after release until the next S instruction.

Source files
------------

// File: rtl/arm_pkg.sv
//------------------------------------------------------------------------------
// Module : arm_pkg
// Purpose: Shared constants and types for the ARM-subset execute stage.
//          ALU opcodes, shifter type encoding and NZCV flag bit positions.
// Ports  : none (package)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package arm_pkg;

    // ALU opcodes carried on EXE_CMD. CMP/TST and LDR/STR reuse these codes.
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Register-operand shift type, instr[6:5].
    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_t;

    // Bit positions inside the {N,Z,C,V} status word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : arm_pkg

`default_nettype wire

// File: rtl/val2_gen.sv
//------------------------------------------------------------------------------
// Module : val2_gen
// Purpose: Second-operand generator. Produces Val2 from the 12-bit shifter
//          operand: zero-extended offset for memory ops, rotated 8-bit
//          immediate, or Rm shifted by a 5-bit immediate amount.
// Ports  : rm_i            Rm register value
//          shift_operand_i instr[11:0]
//          imm_i           shifter operand is a rotated immediate
//          is_mem_i        load/store (takes priority)
//          val2_o          generated second operand
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module val2_gen
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rm_i,
    input  logic [11:0]      shift_operand_i,
    input  logic             imm_i,
    input  logic             is_mem_i,
    output logic [WIDTH-1:0] val2_o
);

    logic [4:0]         w_shamt;
    logic [4:0]         w_rot;
    shift_t             w_type;
    logic [WIDTH-1:0]   w_imm8;
    logic [2*WIDTH-1:0] w_imm_dbl;
    logic [2*WIDTH-1:0] w_rm_dbl;

    assign w_shamt = shift_operand_i[11:7];
    assign w_rot   = {shift_operand_i[11:8], 1'b0};
    assign w_type  = shift_t'(shift_operand_i[6:5]);
    assign w_imm8  = {{(WIDTH-8){1'b0}}, shift_operand_i[7:0]};

    // Rotate right by shifting a doubled copy; the low half is the result.
    // This also makes a rotate of zero an identity without special casing.
    assign w_imm_dbl = {w_imm8, w_imm8} >> w_rot;
    assign w_rm_dbl  = {rm_i, rm_i} >> w_shamt;

    always_comb begin
        val2_o = rm_i;
        if (is_mem_i) begin
            val2_o = {{(WIDTH-12){1'b0}}, shift_operand_i};
        end else if (imm_i) begin
            val2_o = w_imm_dbl[WIDTH-1:0];
        end else begin
            // A shift amount of zero naturally leaves Rm unchanged for all types.
            case (w_type)
                LSL:     val2_o = rm_i << w_shamt;
                LSR:     val2_o = rm_i >> w_shamt;
                ASR:     val2_o = $unsigned($signed(rm_i) >>> w_shamt);
                ROR:     val2_o = w_rm_dbl[WIDTH-1:0];
                default: val2_o = rm_i;
            endcase
        end
    end

endmodule : val2_gen

`default_nettype wire

// File: rtl/exe_stage.sv
//------------------------------------------------------------------------------
// Module : exe_stage
// Purpose: Execute stage of the 5-stage ARM-subset pipeline. Generates Val2,
//          runs the ALU, computes the branch target, owns the NZCV status
//          register and holds the EXE/MEM pipeline register.
// Ports  : clk, rst                      clock, sync active-high reset
//          *_IN                          ID/EXE register outputs
//          WB_EN, MEM_R_EN, MEM_W_EN     registered control to MEM
//          ALU_RES, VAL_RM, Dest         registered result / store data / rd
//          Branch_Taken, Branch_Addr     combinational branch redirect
//          Status                        NZCV register {N,Z,C,V}
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module exe_stage
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WB_EN_IN,
    input  logic             MEM_R_EN_IN,
    input  logic             MEM_W_EN_IN,
    input  logic             B_IN,
    input  logic             S_IN,
    input  logic [3:0]       EXE_CMD_IN,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [WIDTH-1:0] VAL_RN_IN,
    input  logic [WIDTH-1:0] VAL_RM_IN,
    input  logic             IMM_IN,
    input  logic [11:0]      ShiftOperand_IN,
    input  logic [23:0]      Signed_IMM_24_IN,
    input  logic [3:0]       Dest_IN,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic [WIDTH-1:0] ALU_RES,
    output logic [WIDTH-1:0] VAL_RM,
    output logic [3:0]       Dest,
    output logic             Branch_Taken,
    output logic [WIDTH-1:0] Branch_Addr,
    output logic [3:0]       Status
);

    logic [WIDTH-1:0] w_val2;
    logic [WIDTH-1:0] w_opb;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] alu_res_d;
    logic [3:0]       status_d;
    logic             w_c;
    logic             w_v;
    logic             w_defined;

    logic             wb_en_q;
    logic             mem_r_en_q;
    logic             mem_w_en_q;
    logic [WIDTH-1:0] alu_res_q;
    logic [WIDTH-1:0] val_rm_q;
    logic [3:0]       dest_q;
    logic [3:0]       status_q;

    val2_gen #(
        .WIDTH           (WIDTH)
    ) u_val2_gen (
        .rm_i            (VAL_RM_IN),
        .shift_operand_i (ShiftOperand_IN),
        .imm_i           (IMM_IN),
        .is_mem_i        (MEM_R_EN_IN | MEM_W_EN_IN),
        .val2_o          (w_val2)
    );

    // One shared adder: subtraction is Rn + ~Val2 + 1, and SBC's "- ~C" folds
    // into carry-in = C, so the adder carry-out is directly NOT-borrow.
    always_comb begin
        w_opb   = w_val2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (EXE_CMD_IN)
            CMD_ADD: begin w_arith = 1'b1; end
            CMD_ADC: begin w_arith = 1'b1; w_cin = status_q[FLAG_C]; end
            CMD_SUB: begin w_arith = 1'b1; w_opb = ~w_val2; w_cin = 1'b1; end
            CMD_SBC: begin w_arith = 1'b1; w_opb = ~w_val2; w_cin = status_q[FLAG_C]; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, VAL_RN_IN} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        alu_res_d = '0;
        w_defined = 1'b1;
        case (EXE_CMD_IN)
            CMD_MOV: alu_res_d = w_val2;
            CMD_MVN: alu_res_d = ~w_val2;
            CMD_ADD,
            CMD_ADC,
            CMD_SUB,
            CMD_SBC: alu_res_d = w_sum[WIDTH-1:0];
            CMD_AND: alu_res_d = VAL_RN_IN & w_val2;
            CMD_ORR: alu_res_d = VAL_RN_IN | w_val2;
            CMD_EOR: alu_res_d = VAL_RN_IN ^ w_val2;
            default: w_defined = 1'b0;
        endcase
    end

    // Signed overflow: both addends share a sign that the sum does not.
    assign w_c = w_arith & w_sum[WIDTH];
    assign w_v = w_arith & (VAL_RN_IN[WIDTH-1] == w_opb[WIDTH-1])
                         & (w_sum[WIDTH-1] != VAL_RN_IN[WIDTH-1]);

    always_comb begin
        status_d         = 4'b0000;
        status_d[FLAG_N] = w_defined & alu_res_d[WIDTH-1];
        status_d[FLAG_Z] = w_defined & (alu_res_d == '0);
        status_d[FLAG_C] = w_defined & w_c;
        status_d[FLAG_V] = w_defined & w_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= 4'b0000;
            status_q   <= 4'b0000;
        end else begin
            wb_en_q    <= WB_EN_IN;
            mem_r_en_q <= MEM_R_EN_IN;
            mem_w_en_q <= MEM_W_EN_IN;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= VAL_RM_IN;
            dest_q     <= Dest_IN;
            if (S_IN) begin
                status_q <= status_d;
            end
        end
    end

    assign WB_EN        = wb_en_q;
    assign MEM_R_EN     = mem_r_en_q;
    assign MEM_W_EN     = mem_w_en_q;
    assign ALU_RES      = alu_res_q;
    assign VAL_RM       = val_rm_q;
    assign Dest         = dest_q;
    assign Status       = status_q;

    assign Branch_Taken = B_IN;
    assign Branch_Addr  = PC_IN + {{(WIDTH-26){Signed_IMM_24_IN[23]}}, Signed_IMM_24_IN, 2'b00};

endmodule : exe_stage

`default_nettype wire

// File: tb/tb_exe_stage.sv
//------------------------------------------------------------------------------
// Module : tb_exe_stage
// Purpose: Self-checking bench for exe_stage. A behavioural model computes
//          the expected EXE/MEM register, Status and branch outputs with
//          plain integer arithmetic; directed vectors add literal checks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, IMM_IN;
    logic [3:0]  EXE_CMD_IN, Dest_IN;
    logic [31:0] PC_IN, VAL_RN_IN, VAL_RM_IN;
    logic [11:0] ShiftOperand_IN;
    logic [23:0] Signed_IMM_24_IN;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, Branch_Taken;
    logic [31:0] ALU_RES, VAL_RM, Branch_Addr;
    logic [3:0]  Dest, Status;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .WB_EN_IN         (WB_EN_IN),
        .MEM_R_EN_IN      (MEM_R_EN_IN),
        .MEM_W_EN_IN      (MEM_W_EN_IN),
        .B_IN             (B_IN),
        .S_IN             (S_IN),
        .EXE_CMD_IN       (EXE_CMD_IN),
        .PC_IN            (PC_IN),
        .VAL_RN_IN        (VAL_RN_IN),
        .VAL_RM_IN        (VAL_RM_IN),
        .IMM_IN           (IMM_IN),
        .ShiftOperand_IN  (ShiftOperand_IN),
        .Signed_IMM_24_IN (Signed_IMM_24_IN),
        .Dest_IN          (Dest_IN),
        .WB_EN            (WB_EN),
        .MEM_R_EN         (MEM_R_EN),
        .MEM_W_EN         (MEM_W_EN),
        .ALU_RES          (ALU_RES),
        .VAL_RM           (VAL_RM),
        .Dest             (Dest),
        .Branch_Taken     (Branch_Taken),
        .Branch_Addr      (Branch_Addr),
        .Status           (Status)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                           input logic imm, input logic mem);
        logic [31:0] v;
        int          n;
        if (mem) return {20'b0, so};
        if (imm) begin
            v = {24'b0, so[7:0]};
            n = 2 * int'(so[11:8]);
            for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
            return v;
        end
        n = int'(so[11:7]);
        v = rm;
        case (so[6:5])
            2'd0: v = rm << n;
            2'd1: v = rm >> n;
            2'd2: for (int i = 0; i < n; i++) v = {v[31], v[31:1]};
            default: for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
        endcase
        return v;
    endfunction

    // Returns {N,Z,C,V, result}
    function automatic logic [35:0] m_exec(input logic [3:0] cmd, input logic [31:0] rn,
                                           input logic [31:0] v2, input logic [3:0] st);
        longint unsigned ua, ub, cin, full;
        longint          sa, sb, sr;
        logic [31:0]     res;
        logic            c, v;
        ua  = rn;  ub = v2;  cin = st[1];
        sa  = $signed(rn); sb = $signed(v2);
        c   = 1'b0; v = 1'b0; sr = 0;
        case (cmd)
            4'b0001: res = v2;
            4'b1001: res = ~v2;
            4'b0010, 4'b0011: begin
                full = ua + ub + ((cmd == 4'b0011) ? cin : 0);
                res  = full[31:0];
                c    = full[32];
                sr   = sa + sb + ((cmd == 4'b0011) ? longint'(cin) : 0);
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                full = (cmd == 4'b0101) ? (1 - cin) : 0;
                res  = rn - v2 - full[31:0];
                c    = ua >= (ub + full);
                sr   = sa - sb - longint'(full);
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: res = rn & v2;
            4'b0111: res = rn | v2;
            4'b1000: res = rn ^ v2;
            default: return 36'h0;
        endcase
        return {res[31], (res == 32'h0), c, v, res};
    endfunction

    logic [31:0] m_alu, m_rm;
    logic [3:0]  m_dest, m_status;
    logic        m_wb, m_mr, m_mw;
    logic        m_valid = 1'b0;
    logic [35:0] m_out;

    assign m_out = m_exec(EXE_CMD_IN, VAL_RN_IN,
                          m_val2(VAL_RM_IN, ShiftOperand_IN, IMM_IN, MEM_R_EN_IN | MEM_W_EN_IN),
                          m_status);

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_alu <= '0; m_rm <= '0; m_dest <= '0; m_status <= '0;
            m_wb <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
        end else begin
            m_alu  <= m_out[31:0];
            m_rm   <= VAL_RM_IN;
            m_dest <= Dest_IN;
            m_wb   <= WB_EN_IN;
            m_mr   <= MEM_R_EN_IN;
            m_mw   <= MEM_W_EN_IN;
            if (S_IN) m_status <= m_out[35:32];
        end
    end

    // Compare process: inputs change just after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ALU_RES",  ALU_RES, m_alu);
            chk("VAL_RM",   VAL_RM,  m_rm);
            chk("Dest",     {28'b0, Dest},     {28'b0, m_dest});
            chk("WB_EN",    {31'b0, WB_EN},    {31'b0, m_wb});
            chk("MEM_R_EN", {31'b0, MEM_R_EN}, {31'b0, m_mr});
            chk("MEM_W_EN", {31'b0, MEM_W_EN}, {31'b0, m_mw});
            chk("Status",   {28'b0, Status},   {28'b0, m_status});
            chk("Branch_Taken", {31'b0, Branch_Taken}, {31'b0, B_IN});
            chk("Branch_Addr", Branch_Addr,
                PC_IN + 32'(int'($signed(Signed_IMM_24_IN)) * 4));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                         input logic [31:0] rm, input logic imm, input logic [11:0] so,
                         input logic wb, input logic mr, input logic mw, input logic [3:0] rd);
        EXE_CMD_IN = cmd; S_IN = s; VAL_RN_IN = rn; VAL_RM_IN = rm; IMM_IN = imm;
        ShiftOperand_IN = so; WB_EN_IN = wb; MEM_R_EN_IN = mr; MEM_W_EN_IN = mw;
        Dest_IN = rd; B_IN = 1'b0; PC_IN = 32'h0000_1000; Signed_IMM_24_IN = 24'h000010;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick(); tick();
        chk("reset ALU_RES", ALU_RES, 32'h0);
        chk("reset Status", {28'b0, Status}, 32'h0);
        rst = 1'b0;

        // ADD overflow
        drive(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 4'h3);
        tick();
        chk("add ovf res", ALU_RES, 32'h8000_0000);
        chk("add ovf status", {28'b0, Status}, 32'h9);
        chk("add dest", {28'b0, Dest}, 32'h3);

        // SUB to zero then ADC using carry
        drive(4'b0100, 1'b1, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h1);
        tick();
        chk("sub zero res", ALU_RES, 32'h0);
        chk("sub zero status", {28'b0, Status}, 32'h6);
        drive(4'b0011, 1'b0, 32'd1, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 4'h2);
        tick();
        chk("adc res", ALU_RES, 32'd3);

        // Immediate rotate
        drive(4'b0001, 1'b0, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b1, 1'b0, 1'b0, 4'h5);
        tick();
        chk("imm rotate", ALU_RES, 32'hFF00_0000);

        // Register shifts: ASR #4, ROR #0
        drive(4'b0001, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b1, 1'b0, 1'b0, 4'h6);
        tick();
        chk("asr4", ALU_RES, 32'hF800_0000);
        drive(4'b0001, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 12'h060, 1'b1, 1'b0, 1'b0, 4'h6);
        tick();
        chk("ror0", ALU_RES, 32'h8000_0000);

        // STR address and store data
        drive(4'b0010, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 12'h0FC, 1'b0, 1'b0, 1'b1, 4'h0);
        tick();
        chk("str addr", ALU_RES, 32'h1FC);
        chk("str data", VAL_RM, 32'hDEAD_BEEF);
        chk("str mem_w", {31'b0, MEM_W_EN}, 32'h1);

        // Branch, combinational
        drive(4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        B_IN = 1'b1; PC_IN = 32'h20; Signed_IMM_24_IN = 24'hFFFFFE;
        #1;
        chk("branch taken", {31'b0, Branch_Taken}, 32'h1);
        chk("branch addr", Branch_Addr, 32'h18);
        tick();

        // SUB negative (C=0) then SBC consumes borrow
        drive(4'b0100, 1'b1, 32'd3, 32'd5, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h7);
        tick();
        chk("sub neg res", ALU_RES, 32'hFFFF_FFFE);
        chk("sub neg status", {28'b0, Status}, 32'h8);
        drive(4'b0101, 1'b1, 32'd10, 32'h0, 1'b1, 12'h003, 1'b1, 1'b0, 1'b0, 4'h7);
        tick();
        chk("sbc res", ALU_RES, 32'd6);
        chk("sbc status", {28'b0, Status}, 32'h2);

        // Logic ops with LSL/LSR, flags C/V cleared
        drive(4'b0110, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 12'h200, 1'b1, 1'b0, 1'b0, 4'h8);
        tick();
        chk("and lsl", ALU_RES, 32'hF000_F000);
        chk("and status", {28'b0, Status}, 32'h8);
        drive(4'b0111, 1'b1, 32'h1, 32'h80, 1'b0, 12'h3A0, 1'b1, 1'b0, 1'b0, 4'h9);
        tick();
        chk("orr lsr", ALU_RES, 32'h1);
        drive(4'b1000, 1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'hA);
        tick();
        chk("eor zero status", {28'b0, Status}, 32'h4);

        // Undefined opcode: result and flags zero (Z not set)
        drive(4'b1111, 1'b1, 32'h5, 32'h7, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'hB);
        tick();
        chk("undef res", ALU_RES, 32'h0);
        chk("undef status", {28'b0, Status}, 32'h0);

        // MVN sets N, then reset with a competing S instruction
        drive(4'b1001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0, 4'hC);
        tick();
        chk("mvn res", ALU_RES, 32'hFFFF_FFFF);
        chk("mvn status", {28'b0, Status}, 32'h8);
        rst = 1'b1;
        drive(4'b0100, 1'b1, 32'h0, 32'h1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 4'hD);
        tick();
        chk("rst res", ALU_RES, 32'h0);
        chk("rst status", {28'b0, Status}, 32'h0);
        chk("rst ctrl", {29'b0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'h0);
        chk("rst rm/dest", VAL_RM | {28'b0, Dest}, 32'h0);
        rst = 1'b0;
        drive(4'b0010, 1'b0, 32'd2, 32'h0, 1'b1, 12'h003, 1'b1, 1'b0, 1'b0, 4'h4);
        tick();
        chk("post rst res", ALU_RES, 32'd5);
        chk("post rst status", {28'b0, Status}, 32'h0);
        tick();
        chk("status held", {28'b0, Status}, 32'h0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_exe_stage

`default_nettype wire
